piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: accepts a WIDTH-bit word via a valid/ready
//  handshake and shifts it out one bit per clk on tx_out, framed by a start bit (0)
//  and a stop bit (1). Transmit-side counterpart to the team's registered capture/
//  deserializer path; the line idles high between frames.
// PARAMETERS
//  WIDTH      8   data bits per frame (>=2)
//  LSB_FIRST  1   1: data_in[0] sent first; 0: data_in[WIDTH-1] sent first
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  rst         in   1      reset, synchronous, active-high
//  load_valid  in   1      data_in holds a word to send
//  load_ready  out  1      block can accept a word this cycle
//  data_in     in   WIDTH  parallel word, sampled only on accept
//  tx_out      out  1      serial line, idle high
//  busy        out  1      frame in progress (START/DATA/STOP)
//  done        out  1      1-cycle pulse in the STOP-bit cycle
// BEHAVIOUR
//  - Reset (clk; rst=1): state=IDLE, tx_out=1, busy=0, done=0, shift reg=0,
//    bit count=0. load_ready is decoded from state, so it is 1 after reset.
//  - All outputs except load_ready are registered. load_ready=1 in IDLE and in STOP,
//    else 0.
//  - Accept = load_valid & load_ready at posedge. On accept: capture data_in,
//    state->START. data_in is ignored at all other times.
//  - FSM (one cycle per state visit unless noted):
//    IDLE : tx_out=1, busy=0. Accept -> START, else stay.
//    START: tx_out=0, busy=1. -> DATA, count=0.
//    DATA : tx_out=current bit, busy=1. Shift per LSB_FIRST, count+1.
//           Stays WIDTH cycles; at count==WIDTH-1 -> STOP.
//    STOP : tx_out=1, busy=1, done=1. Accept -> START (back-to-back, no idle gap),
//           else -> IDLE.
//  - Timing: accept at edge N -> tx_out=0 in cycle N+1 -> data bits in cycles
//    N+2..N+WIDTH+1 -> stop bit in cycle N+WIDTH+2. Frame length = WIDTH+2 cycles.
//  - Count width = $clog2(WIDTH); it never exceeds WIDTH-1.
//  - Boundary cases:
//    rst mid-frame: abort immediately. Next cycle tx_out=1, IDLE, no done pulse.
//    rst and load_valid together: rst wins, word not accepted.
//    load_valid held high: one word is accepted per frame, in IDLE or STOP only.
//    data_in changes during frame: no effect on the frame in flight.
//    Back-to-back frames: line sequence ...,stop(1),start(0),... with no extra idle bit.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2,
//    STOP=2'd3), START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
//  - One sub-module, piso_shift_reg #(WIDTH, LSB_FIRST)
//    (clk, rst, load, shift, d, bit_out). piso_serializer holds the FSM, the bit
//    counter and the output registers.
// TESTING  (WIDTH=8, LSB_FIRST=1 unless noted)
//  1. Reset: rst=1 for 2 clk -> tx_out=1, busy=0, done=0, load_ready=1.
//  2. Single frame: data_in=8'hA5, valid for 1 cycle -> tx_out=0,1,0,1,0,0,1,0,1,1
//     (start, LSB..MSB, stop); done high exactly in the stop cycle; then IDLE.
//  3. Back-to-back: 8'h3C then 8'hFF, valid held high -> 2nd start bit directly
//     follows 1st stop bit; 20 consecutive frame cycles; 2 done pulses.
//  4. MSB-first (LSB_FIRST=0): 8'h81 -> tx_out=0,1,0,0,0,0,0,0,1,1.
//  5. Reset mid-frame: assert rst in 4th data cycle of 8'h00 -> next cycle tx_out=1,
//     busy=0, no done pulse; a new word is accepted normally afterwards.
//  6. Handshake: pulse load_valid during DATA and change data_in -> no accept; the
//     in-flight frame is bit-exact; load_ready=0 throughout START/DATA.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter: FSM state
// encoding, line levels for framing, and a counter-width helper.
package piso_serializer_pkg;

  // State encoding values, kept as plain localparams so checkers and
  // waveform decoders can reference them without the enum type.
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    START = ST_START_ENC,
    DATA  = ST_DATA_ENC,
    STOP  = ST_STOP_ENC
  } state_t;

  // Line levels used to frame each word.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Bit-counter width: enough to count 0..width-1, never narrower than 1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_shift_reg.sv
// Data shift register for the serializer. Loads a full word, then presents
// one bit at a time on bit_out, advancing on each shift strobe. The
// direction is fixed at elaboration by LSB_FIRST; vacated bits fill with 0.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             bit_out
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  // Next value after one shift: the bit just sent falls off the output end.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_shifted = {1'b0, r_q[WIDTH-1:1]};
      assign bit_out   = r_q[0];
    end else begin : g_msb
      assign w_shifted = {r_q[WIDTH-2:0], 1'b0};
      assign bit_out   = r_q[WIDTH-1];
    end
  endgenerate

  // Load has priority over shift; reset clears the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      r_q <= w_shifted;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a
// valid/ready handshake and sends start bit, WIDTH data bits, stop bit on
// tx_out, one bit per clock. The line idles high between frames.
//
// Handshake: a word is accepted on a rising clk edge where load_valid and
// load_ready are both 1; data_in is sampled only at that edge. load_ready
// is a pure decode of the state (1 in IDLE and STOP), so an accept in STOP
// starts the next frame with no idle bit between stop and start.
//
// tx_out, busy and done are registered: the combinational block computes
// the value each output must take in the state being entered, and that
// value is captured together with the state.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic          w_tx_next;
  logic          w_busy_next;
  logic          w_done_next;
  logic          w_accept;
  logic          w_load;
  logic          w_shift;
  logic          w_bit;

  assign load_ready = (r_state == IDLE) || (r_state == STOP);
  assign w_accept   = load_valid && load_ready;

  assign tx_out    = r_tx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .shift   (w_shift),
    .d       (data_in),
    .bit_out (w_bit)
  );

  // State, bit counter and output registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tx    <= IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Next state, counter and next output values for the state being entered.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_tx_next    = IDLE_LEVEL;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = START;
          w_load       = 1'b1;
          w_tx_next    = START_BIT;
          w_busy_next  = 1'b1;
        end
      end

      START: begin
        // First data bit goes on the line; advance the register so the
        // following bit is ready for the next cycle.
        w_state_next = DATA;
        w_cnt_next   = '0;
        w_shift      = 1'b1;
        w_tx_next    = w_bit;
        w_busy_next  = 1'b1;
      end

      DATA: begin
        w_busy_next = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_next = STOP;
          w_tx_next    = STOP_BIT;
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
          w_shift    = 1'b1;
          w_tx_next  = w_bit;
        end
      end

      STOP: begin
        if (w_accept) begin
          w_state_next = START;
          w_load       = 1'b1;
          w_tx_next    = START_BIT;
          w_busy_next  = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
